// File: rtl/ram_pkg.sv
// Shared helpers for the byte-enabled RAM family: lane arithmetic, the
// lane merge used by both the write path and the read bypass, and the
// read-latency encodings.
package ram_pkg;

    localparam int LAT_DIRECT  = 1;
    localparam int LAT_OUT_REG = 2;

    function automatic int lanes(input int width);
        return width / 8;
    endfunction

    function automatic int read_latency(input int out_reg);
        return (out_reg != 0) ? LAT_OUT_REG : LAT_DIRECT;
    endfunction

    function automatic logic [7:0] lane_merge(input logic [7:0] old_lane,
                                              input logic [7:0] new_lane,
                                              input logic       be);
        return be ? new_lane : old_lane;
    endfunction

endpackage

// File: rtl/ram_be_array.sv
// Plain byte-enabled storage shaped for block-RAM inference: one write port,
// one registered read port with old-data semantics, no reset on contents.
module ram_be_array
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic                            clk,
    input  logic                            we,
    input  logic [AW-1:0]                   waddr,
    input  logic [lanes(DATA_WIDTH)-1:0]    wbe,
    input  logic [DATA_WIDTH-1:0]           wdata,
    input  logic                            re,
    input  logic [AW-1:0]                   raddr,
    output logic [DATA_WIDTH-1:0]           rdata
);

    localparam int LANES = lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write: lanes with a clear enable keep their stored value
    always_ff @(posedge clk) begin
        if (we) begin
            for (int n = 0; n < LANES; n++) begin
                mem[waddr][n*8 +: 8] <= lane_merge(mem[waddr][n*8 +: 8], wdata[n*8 +: 8], wbe[n]);
            end
        end
    end

    // Registered read; a same-edge write to the same word is not visible here
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_be.sv
// Simple-dual-port RAM with byte enables, out-of-range handling, optional
// read-during-write forwarding, optional output register and a valid strobe.
module ram_be
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int OUT_REG    = 0,
    parameter int BYPASS     = 1
)(
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_we,
    input  logic [ADDR_WIDTH-1:0]           i_waddr,
    input  logic [lanes(DATA_WIDTH)-1:0]    i_wbe,
    input  logic [DATA_WIDTH-1:0]           i_wdata,
    input  logic                            i_re,
    input  logic [ADDR_WIDTH-1:0]           i_raddr,
    output logic [DATA_WIDTH-1:0]           o_rdata,
    output logic                            o_rvalid
);

    localparam int LANES        = lanes(DATA_WIDTH);
    localparam int ARRAY_AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int READ_LATENCY = read_latency(OUT_REG);
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DEPTH);

    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_chk_width
        $error("ram_be: DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || longint'(DEPTH) > (longint'(1) << ADDR_WIDTH)) begin : g_chk_depth
        $error("ram_be: DEPTH must be between 1 and 2**ADDR_WIDTH");
    end
    if (OUT_REG != 0 && OUT_REG != 1) begin : g_chk_out_reg
        $error("ram_be: OUT_REG must be 0 or 1");
    end
    if (BYPASS != 0 && BYPASS != 1) begin : g_chk_bypass
        $error("ram_be: BYPASS must be 0 or 1");
    end

    logic                  w_in_range;
    logic                  r_in_range;
    logic                  w_en;
    logic                  r_en;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] array_rdata;

    logic                  s1_valid;
    logic                  s1_oor;
    logic                  rd_seen;
    logic [LANES-1:0]      s1_fwd_be;
    logic [DATA_WIDTH-1:0] s1_wdata;
    logic [DATA_WIDTH-1:0] s1_data;

    // Full-width compare against DEPTH so out-of-range addresses never alias
    assign w_in_range = ({1'b0, i_waddr} < DEPTH_LIMIT);
    assign r_in_range = ({1'b0, i_raddr} < DEPTH_LIMIT);

    // Requests sampled while reset is held are dropped
    assign w_en    = i_we & i_rst_n & w_in_range;
    assign r_en    = i_re & i_rst_n;
    assign fwd_hit = (BYPASS != 0) && w_en && r_en && (i_waddr == i_raddr);

    ram_be_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (ARRAY_AW)
    ) u_array (
        .clk   (i_clk),
        .we    (w_en),
        .waddr (i_waddr[ARRAY_AW-1:0]),
        .wbe   (i_wbe),
        .wdata (i_wdata),
        .re    (r_en & r_in_range),
        .raddr (i_raddr[ARRAY_AW-1:0]),
        .rdata (array_rdata)
    );

    // Capture read qualifiers and forwarding lanes in step with the array read
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid  <= 1'b0;
            s1_oor    <= 1'b0;
            rd_seen   <= 1'b0;
            s1_fwd_be <= '0;
            s1_wdata  <= '0;
        end else begin
            s1_valid <= r_en;
            if (r_en) begin
                s1_oor    <= !r_in_range;
                rd_seen   <= 1'b1;
                s1_fwd_be <= fwd_hit ? i_wbe : '0;
                s1_wdata  <= i_wdata;
            end
        end
    end

    // Resolve the returned word: zero before any read or when out of range, else lane-merged
    always_comb begin
        s1_data = '0;
        if (rd_seen && !s1_oor) begin
            for (int n = 0; n < LANES; n++) begin
                s1_data[n*8 +: 8] = lane_merge(array_rdata[n*8 +: 8], s1_wdata[n*8 +: 8], s1_fwd_be[n]);
            end
        end
    end

    if (READ_LATENCY == LAT_OUT_REG) begin : g_out_reg
        logic [DATA_WIDTH-1:0] s2_data;
        logic                  s2_valid;

        // Extra output stage; data only advances with a valid read so it holds between reads
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                s2_valid <= 1'b0;
                s2_data  <= '0;
            end else begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
        end

        assign o_rdata  = s2_data;
        assign o_rvalid = s2_valid;
    end else begin : g_direct
        assign o_rdata  = s1_data;
        assign o_rvalid = s1_valid;
    end

endmodule

// File: tb/tb_ram_be.sv
// Bench for ram_be: two instances share one stimulus stream, one with
// OUT_REG=0/BYPASS=1 and one with OUT_REG=1/BYPASS=0, each checked against a
// reference memory model through its own queue of expected read results.
module tb_ram_be;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1000;
    localparam int LAT_A = 1;
    localparam int LAT_B = 2;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rst_hold;
    logic          we;
    logic [AW-1:0] waddr;
    logic [3:0]    wbe;
    logic [DW-1:0] wdata;
    logic          re;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata_a;
    logic          rvalid_a;
    logic [DW-1:0] rdata_b;
    logic          rvalid_b;

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] last_a;
    logic [DW-1:0] last_b;
    logic [DW-1:0] model [DEPTH];

    ram_be #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEPTH), .OUT_REG (0), .BYPASS (1)
    ) dut_a (
        .i_clk (clk), .i_rst_n (rst_n), .i_we (we), .i_waddr (waddr), .i_wbe (wbe),
        .i_wdata (wdata), .i_re (re), .i_raddr (raddr), .o_rdata (rdata_a), .o_rvalid (rvalid_a)
    );

    ram_be #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .DEPTH (DEPTH), .OUT_REG (1), .BYPASS (0)
    ) dut_b (
        .i_clk (clk), .i_rst_n (rst_n), .i_we (we), .i_waddr (waddr), .i_wbe (wbe),
        .i_wdata (wdata), .i_re (re), .i_raddr (raddr), .o_rdata (rdata_b), .o_rvalid (rvalid_b)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    // Count rising edges so queued results know when they are due
    always @(posedge clk) cyc <= cyc + 1;

    // Reference lane merge built from a byte mask
    function automatic logic [DW-1:0] merge_word(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [3:0]    be);
        logic [DW-1:0] mask;
        for (int n = 0; n < 4; n++) mask[n*8 +: 8] = {8{be[n]}};
        return (new_w & mask) | (old_w & ~mask);
    endfunction

    // Drive one cycle of stimulus after the falling edge, queue expected reads and update the model
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [3:0] be,
                         input logic [DW-1:0] wd, input logic r, input logic [AW-1:0] ra);
        logic [DW-1:0] old_w;
        exp_t          ea;
        exp_t          eb;
        @(negedge clk);
        #1;
        rst_n = rst_hold;
        we    = w;
        waddr = wa;
        wbe   = be;
        wdata = wd;
        re    = r;
        raddr = ra;
        if (rst_hold) begin
            if (r) begin
                old_w   = (int'(ra) < DEPTH) ? model[ra] : '0;
                ea.due  = cyc + LAT_A;
                eb.due  = cyc + LAT_B;
                ea.data = (w && wa == ra && int'(ra) < DEPTH) ? merge_word(old_w, wd, be) : old_w;
                eb.data = old_w;
                qa.push_back(ea);
                qb.push_back(eb);
            end
            if (w && int'(wa) < DEPTH) model[wa] = merge_word(model[wa], wd, be);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 4'h0, '0, 1'b0, '0);
    endtask

    // Scoreboard consumer: every cycle each output is either the due result or idle holding its last value
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            checks++;
            if (rvalid_a !== 1'b0 || rdata_a !== '0) begin
                errors++;
                $display("[TB] FAIL reset_out_a: rvalid=%0b rdata=%h, required rvalid=0 rdata=0", rvalid_a, rdata_a);
            end
            checks++;
            if (rvalid_b !== 1'b0 || rdata_b !== '0) begin
                errors++;
                $display("[TB] FAIL reset_out_b: rvalid=%0b rdata=%h, required rvalid=0 rdata=0", rvalid_b, rdata_b);
            end
            last_a = '0;
            last_b = '0;
        end else begin
            if (qa.size() != 0 && qa[0].due == cyc) begin
                e = qa.pop_front();
                checks++;
                if (rvalid_a !== 1'b1 || rdata_a !== e.data) begin
                    errors++;
                    $display("[TB] FAIL read_a cyc %0d: rvalid=%0b rdata=%h, required rvalid=1 rdata=%h", cyc, rvalid_a, rdata_a, e.data);
                end
                last_a = e.data;
            end else begin
                checks++;
                if (rvalid_a !== 1'b0 || rdata_a !== last_a) begin
                    errors++;
                    $display("[TB] FAIL idle_a cyc %0d: rvalid=%0b rdata=%h, required rvalid=0 rdata=%h", cyc, rvalid_a, rdata_a, last_a);
                end
            end
            if (qb.size() != 0 && qb[0].due == cyc) begin
                e = qb.pop_front();
                checks++;
                if (rvalid_b !== 1'b1 || rdata_b !== e.data) begin
                    errors++;
                    $display("[TB] FAIL read_b cyc %0d: rvalid=%0b rdata=%h, required rvalid=1 rdata=%h", cyc, rvalid_b, rdata_b, e.data);
                end
                last_b = e.data;
            end else begin
                checks++;
                if (rvalid_b !== 1'b0 || rdata_b !== last_b) begin
                    errors++;
                    $display("[TB] FAIL idle_b cyc %0d: rvalid=%0b rdata=%h, required rvalid=0 rdata=%h", cyc, rvalid_b, rdata_b, last_b);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (rvalid_a !== 1'b0 || rdata_a !== '0) begin
            errors++;
            $display("[TB] FAIL por_a: rvalid=%0b rdata=%h, required 0/0", rvalid_a, rdata_a);
        end
        checks++;
        if (rvalid_b !== 1'b0 || rdata_b !== '0) begin
            errors++;
            $display("[TB] FAIL por_b: rvalid=%0b rdata=%h, required 0/0", rvalid_b, rdata_b);
        end
        rst_hold = 1'b1;
        idle(3);
    endtask

    task automatic test_write_read();
        drive(1'b1, 10'h005, 4'hF, 32'hDEADBEEF, 1'b0, '0);
        idle(2);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h005);
        idle(4);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL write_read_drain: pending a=%0d b=%0d, required 0/0", qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic test_byte_enable();
        drive(1'b1, 10'h010, 4'hF, 32'h11223344, 1'b0, '0);
        drive(1'b1, 10'h010, 4'b0101, 32'hAABBCCDD, 1'b0, '0);
        idle(1);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h010);
        idle(3);
        checks++;
        if (model[10'h010] !== 32'h11BB33DD || qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL byte_enable_drain: model=%h pending a=%0d b=%0d, required 11bb33dd 0/0",
                     model[10'h010], qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic test_read_during_write();
        drive(1'b1, 10'h020, 4'hF, 32'h00000000, 1'b0, '0);
        drive(1'b1, 10'h021, 4'hF, 32'h01020304, 1'b0, '0);
        idle(1);
        drive(1'b1, 10'h020, 4'hF, 32'hCAFEF00D, 1'b1, 10'h020);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h020);
        drive(1'b1, 10'h021, 4'b0011, 32'hF0F0F0F0, 1'b1, 10'h021);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h021);
        idle(4);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL rdw_drain: pending a=%0d b=%0d, required 0/0", qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) drive(1'b1, AW'(i), 4'hF, 32'hA0 + i, 1'b0, '0);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 4'h0, '0, 1'b1, AW'(i));
        idle(4);
        drive(1'b1, 10'h030, 4'hF, 32'h13579BDF, 1'b1, 10'h000);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h030);
        idle(4);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL back_to_back_drain: pending a=%0d b=%0d, required 0/0", qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic test_zero_wbe();
        drive(1'b1, 10'h005, 4'h0, 32'hFFFFFFFF, 1'b0, '0);
        idle(1);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h005);
        idle(3);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_wbe_drain: pending a=%0d b=%0d, required 0/0", qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 10'd999, 4'hF, 32'h99999999, 1'b0, '0);
        drive(1'b1, 10'd1010, 4'hF, 32'h12345678, 1'b0, '0);
        drive(1'b1, 10'd1000, 4'hF, 32'h87654321, 1'b0, '0);
        idle(1);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'd1010);
        drive(1'b1, 10'd1023, 4'hF, 32'h5A5A5A5A, 1'b1, 10'd1023);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'd999);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'd1000);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'd10);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'd16);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'd5);
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 4'h0, '0, 1'b1, AW'(i));
        idle(4);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL out_of_range_drain: pending a=%0d b=%0d, required 0/0", qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h005);
        idle(3);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h010);
        @(negedge clk);
        #2;
        rst_hold = 1'b0;
        rst_n    = 1'b0;
        re       = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        checks++;
        if (rvalid_a !== 1'b0 || rdata_a !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_a: rvalid=%0b rdata=%h, required 0/0", rvalid_a, rdata_a);
        end
        checks++;
        if (rvalid_b !== 1'b0 || rdata_b !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_b: rvalid=%0b rdata=%h, required 0/0", rvalid_b, rdata_b);
        end
        drive(1'b1, 10'h005, 4'hF, 32'hBADBADBA, 1'b1, 10'h005);
        idle(1);
        rst_hold = 1'b1;
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h005);
        drive(1'b0, '0, 4'h0, '0, 1'b1, 10'h010);
        idle(4);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL mid_reset_drain: pending a=%0d b=%0d, required 0/0", qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                  DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)));
        end
        idle(4);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_drain: pending a=%0d b=%0d, required 0/0", qa.size(), qb.size());
            qa.delete(); qb.delete();
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_hold = 1'b0;
        rst_n    = 1'b1;
        we       = 1'b0;
        waddr    = '0;
        wbe      = '0;
        wdata    = '0;
        re       = 1'b0;
        raddr    = '0;
        last_a   = '0;
        last_b   = '0;
        #2;
        rst_n = 1'b0;
        test_reset();
        test_write_read();
        test_byte_enable();
        test_read_during_write();
        test_back_to_back();
        test_zero_wbe();
        test_out_of_range();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_be.md
Name: ram_be

Overview:
Parametrised simple-dual-port synchronous RAM with independent read and write ports, per-byte write enables and an optional output register.
- Read data is qualified by a valid strobe.
- Read-during-write to the same address is resolved deterministically, with optional forwarding of the new data.
- Serves as data memory and scratch buffers for the RISC-V core, replacing the fixed-width single-address RAM wrapper.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8 (elaboration error otherwise)
ADDR_WIDTH, 10, word-address width
DEPTH, 1024, number of words implemented; must be <= 2**ADDR_WIDTH
OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2 cycles
BYPASS, 1, 1 = read-during-write returns new data; 0 = returns old data

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_we  in  1  write request
i_waddr  in  ADDR_WIDTH  write word address
i_wbe  in  DATA_WIDTH/8  byte-lane write enables, bit n controls bits [8n+7:8n]
i_wdata  in  DATA_WIDTH  write data
i_re  in  1  read request
i_raddr  in  ADDR_WIDTH  read word address
o_rdata  out  DATA_WIDTH  read data
o_rvalid  out  1  o_rdata carries the result of a read request this cycle

Behaviour:
Clock and reset:
- One clock, i_clk.
- Reset i_rst_n is asynchronous and active-low.
- While i_rst_n = 0: o_rvalid = 0, o_rdata = 0, all read-pipeline valid bits cleared.
- Memory array contents are not reset; they are retained across reset.

Write port:
- At a rising edge with i_we = 1, each lane with i_wbe[n] = 1 is written; lanes with i_wbe[n] = 0 keep their old value.
- i_we = 1 with i_wbe = 0 performs no write.
- i_waddr >= DEPTH: write is ignored.

Read port:
- i_re and i_raddr are sampled at a rising edge (cycle T).
- OUT_REG=0: o_rdata and o_rvalid = 1 are presented in cycle T+1.
- OUT_REG=1: they are presented in cycle T+2.
- Back-to-back reads are accepted every cycle, giving full throughput.
- o_rvalid is 1 for exactly one cycle per accepted read.
- o_rdata holds its last value while o_rvalid = 0; it is not cleared between reads.
- i_raddr >= DEPTH: returns all zeros with o_rvalid = 1.

Read-during-write (i_re = 1, i_we = 1, i_raddr == i_waddr, same edge):
- BYPASS=1: each lane of the returned word takes i_wdata if i_wbe[n] = 1, else the stored old lane value.
- BYPASS=0: returns the full old word.
- The write completes in both cases.
- Different addresses on the same edge: fully independent.

Reset mid-operation:
- Reads in flight at reset assertion are discarded; no o_rvalid pulse is ever produced for them.
- Writes sampled on an edge while i_rst_n = 0 are ignored.
- The first read accepted is on the first rising edge with i_rst_n = 1.

Widths and elaboration:
- Address comparison uses the full ADDR_WIDTH; there is no wrap-around for out-of-range addresses.
- Lane count is DATA_WIDTH/8.
- Elaboration checks: DATA_WIDTH % 8 == 0, DEPTH <= 2**ADDR_WIDTH, OUT_REG in {0,1}, BYPASS in {0,1}.

Decomposition:
Shared package ram_pkg:
- function lanes(width) returning width/8
- function lane_merge(old, new, be) used by both write and bypass paths
- localparams for latency encodings

Sub-module ram_be_array:
- Plain storage for block-RAM inference.
- Byte-enabled write, registered synchronous read, old-data semantics, no reset.

Top ram_be adds:
- address range check
- bypass comparator and merge, registered in parallel with the array read
- optional output stage
- valid pipeline

Test Plan:
- Write 0xDEADBEEF @0x005, wbe=1111; later read @0x005 -> o_rdata=0xDEADBEEF, o_rvalid=1 exactly 1 cycle later (OUT_REG=0), 2 cycles later (OUT_REG=1).
- Preload 0x11223344 @0x010; write 0xAABBCCDD wbe=0101; read -> 0x11BB33DD.
- Same-edge write 0xCAFEF00D wbe=1111 and read @0x020, old 0x00000000: BYPASS=1 -> 0xCAFEF00D, BYPASS=0 -> 0x00000000; following read -> 0xCAFEF00D in both.
- Reads @0,1,2,3 on 4 consecutive edges after writing 0xA0..0xA3 -> o_rvalid high 4 consecutive cycles, data 0xA0,0xA1,0xA2,0xA3 in order; o_rdata stays 0xA3 after.
- DEPTH=1000, ADDR_WIDTH=10: write @1010 then read @1010 -> 0x00000000 with o_rvalid=1; array unchanged at all valid addresses.
- Issue read, assert i_rst_n=0 before its result (OUT_REG=1) -> o_rvalid and o_rdata drop to 0 immediately, no pulse after release; previously written words still read back correctly.
